instruction_fetch_controller: RTL
=================================

Name: instruction_fetch_controller

Overview:
- Sequences the single-ported, combinational-read instruction memory for the processor front end.
- Owns the program counter and drives the memory read address, one word per cycle.
- Buffers fetched words in a 2-entry queue with a valid/ready handshake toward decode.
- Handles branch redirect, halt, end-of-program and misaligned targets.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address (byte address).
- MEM_WORDS, 6, number of 32-bit words in instruction memory; end address = MEM_WORDS*4.
- RESET_PC, 0, PC value loaded on reset (must be word-aligned).
- QUEUE_DEPTH, 2, fetch queue entries (fixed at 2; other values are not supported).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- imemAddress  output  ADDR_WIDTH  byte address to instruction memory; memory returns the word at imemAddress/4 in the same cycle.
- imemInstruction  input  32  combinational read data from instruction memory.
- fetchValid  output  1  queue head holds a valid instruction.
- fetchReady  input  1  decode accepts the head this cycle.
- fetchInstruction  output  32  instruction at queue head.
- fetchPC  output  ADDR_WIDTH  byte address of the head instruction.
- branchTaken  input  1  one-cycle redirect request.
- branchTarget  input  ADDR_WIDTH  redirect byte address.
- halt  input  1  level: stop issuing new fetches while high.
- done  output  1  program exhausted and queue drained.
- misaligned  output  1  sticky error: redirect target not word-aligned.

Behaviour:
- Reset (reset=0, asynchronous):
  - PC=RESET_PC; queue emptied; state=FETCH.
  - fetchValid=0, fetchInstruction=0, fetchPC=0, done=0, misaligned=0.
  - imemAddress=RESET_PC.
- imemAddress always equals the PC register; it is combinational from the PC and never from inputs.
- States:
  - FETCH: issues fetches.
  - END: PC == MEM_WORDS*4, no fetches.
  - ERROR: misaligned target seen, terminal until reset.
- Pop: fetchValid && fetchReady at a rising edge removes the head. fetchValid=1 iff count>0. Head outputs hold stable while fetchValid=1 and fetchReady=0.
- Push in FETCH: when halt=0, no redirect, and (count<2 or pop this cycle):
  - store {PC, imemInstruction} at the tail;
  - PC <= PC+4.
  - Latency: a word read at cycle N is visible at the head no earlier than cycle N+1.
  - Throughput: 1 instruction/cycle with fetchReady held high.
- Full: count==2 and no pop → no push, PC holds, imemAddress is unchanged.
- Simultaneous push and pop: count is unchanged; both take effect.
- Redirect (branchTaken=1 at an edge):
  - Any pop completing this cycle still completes.
  - All other entries are flushed (count <= 0), and there is no push this cycle.
  - If branchTarget[1:0]==0: PC <= branchTarget. State becomes FETCH if the target < MEM_WORDS*4, otherwise END.
  - Else: misaligned <= 1, state <= ERROR, PC holds.
  - Redirect takes priority over halt and push.
- halt=1: no pushes and PC frozen; pops continue, so the queue drains. Redirects are still honoured. Deasserting halt resumes fetching the next cycle.
- END:
  - Entered when a push advances PC to MEM_WORDS*4.
  - The queue drains normally.
  - done=1 when state==END and count==0 (registered; asserts the cycle after the last pop).
  - A redirect out of END to a valid target clears done and returns to FETCH.
- ERROR:
  - No pushes; the queue is flushed; fetchValid=0.
  - done stays 0; branchTaken is ignored.
  - Only reset exits ERROR.
- PC arithmetic is modulo 2^ADDR_WIDTH. In practice it never exceeds MEM_WORDS*4, because fetching stops there.
- Reset asserted mid-operation: all state is cleared immediately, without waiting for a clock edge. The first fetch occurs at the first rising edge after reset deasserts.

Test Plan:
- Straight-line program: memory words 0..5 = 0xA0..0xA5, fetchReady=1 → fetchPC sequence 0,4,8,12,16,20 on consecutive cycles; done=1 one cycle after PC=20 is popped; imemAddress stops at 24.
- Backpressure: fetchReady=0 for 5 cycles after reset → count saturates at 2, PC=8, head holds PC=0/0xA0; releasing fetchReady delivers PC 0,4,8 back-to-back with no duplicates or gaps.
- Branch with simultaneous pop: queue holds PC 4,8 with fetchReady=1; branchTaken=1, branchTarget=0 → PC=4 is consumed; PC=8 is flushed; next fetchPC=0 appears one cycle later.
- Misaligned redirect: branchTarget=0x6 → misaligned=1, fetchValid=0, further branchTaken ignored; after a reset pulse, misaligned=0 and fetch restarts at 0.
- Halt: halt=1 at PC=8 with 2 queued → both drain, PC stays 8, imemAddress=8; halt=0 → next fetchPC=8.
- Async reset mid-run: drop reset between clock edges at PC=16 → outputs clear immediately (fetchValid=0, imemAddress=0) without a clock edge.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_controller
// Purpose  : Front-end fetch sequencer. Owns the PC, reads one word per cycle
//            from a combinational-read instruction memory and buffers the
//            fetched words in a 2-entry queue toward decode. Handles branch
//            redirects, halt, end-of-program and misaligned redirect targets.
// Ports    : clock/reset        - clock, async active-low reset
//            imemAddress        - byte address to instruction memory (= PC)
//            imemInstruction    - combinational read data for imemAddress
//            fetchValid/Ready   - valid/ready handshake of the queue head
//            fetchInstruction   - instruction word at the queue head
//            fetchPC            - byte address of the queue head
//            branchTaken/Target - one-cycle redirect request and target
//            halt               - level; freezes fetching while high
//            done               - program exhausted and queue drained
//            misaligned         - sticky error: unaligned redirect target
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_controller #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_WORDS   = 6,
  parameter int RESET_PC    = 0,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imemAddress,
  input  logic [31:0]           imemInstruction,
  output logic                  fetchValid,
  input  logic                  fetchReady,
  output logic [31:0]           fetchInstruction,
  output logic [ADDR_WIDTH-1:0] fetchPC,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic                  halt,
  output logic                  done,
  output logic                  misaligned
);

  localparam logic [ADDR_WIDTH-1:0] END_ADDR  = ADDR_WIDTH'(MEM_WORDS * 4);
  localparam logic [ADDR_WIDTH-1:0] START_PC  = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

  // The queue is a shift structure hard-wired for two entries.
  generate
    if (QUEUE_DEPTH != 2) begin : g_bad_depth
      $error("instruction_fetch_controller: QUEUE_DEPTH must be 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_END   = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [1:0]              count_q, count_d;
  // Entry 0 is always the head; entry 1 shifts down on a pop.
  logic [ADDR_WIDTH-1:0]   qpc0_q, qpc0_d, qpc1_q, qpc1_d;
  logic [31:0]             qins0_q, qins0_d, qins1_q, qins1_d;
  logic                    done_q, done_d;
  logic                    mis_q, mis_d;

  logic                    pop;
  logic                    redirect;
  logic                    push;
  logic [1:0]              count_after_pop;
  logic [ADDR_WIDTH-1:0]   pc_next_seq;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    count_d         = count_q;
    qpc0_d          = qpc0_q;
    qpc1_d          = qpc1_q;
    qins0_d         = qins0_q;
    qins1_d         = qins1_q;
    mis_d           = mis_q;
    count_after_pop = count_q;
    pc_next_seq     = pc_q + WORD_STEP;

    pop      = (count_q != 2'd0) && fetchReady;
    redirect = branchTaken && (state_q != S_ERROR);
    push     = (state_q == S_FETCH) && !halt && !redirect &&
               ((count_q != 2'd2) || pop);

    if (redirect) begin
      // A completing pop needs no action here: every entry is dropped anyway.
      count_d = 2'd0;
      if (branchTarget[1:0] == 2'b00) begin
        pc_d    = branchTarget;
        state_d = (branchTarget < END_ADDR) ? S_FETCH : S_END;
      end else begin
        mis_d   = 1'b1;
        state_d = S_ERROR;
      end
    end else begin
      if (pop) begin
        qpc0_d          = qpc1_q;
        qins0_d         = qins1_q;
        count_after_pop = count_q - 2'd1;
      end
      count_d = count_after_pop;
      if (push) begin
        // Tail slot is whatever index follows the surviving entries.
        if (count_after_pop == 2'd0) begin
          qpc0_d  = pc_q;
          qins0_d = imemInstruction;
        end else begin
          qpc1_d  = pc_q;
          qins1_d = imemInstruction;
        end
        count_d = count_after_pop + 2'd1;
        pc_d    = pc_next_seq;
        if (pc_next_seq == END_ADDR) begin
          state_d = S_END;
        end
      end
    end

    if (state_q == S_ERROR) begin
      count_d = 2'd0;
    end

    // Registered from next-state so done rises the cycle after the last pop.
    done_d = (state_d == S_END) && (count_d == 2'd0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= START_PC;
      count_q <= 2'd0;
      qpc0_q  <= '0;
      qpc1_q  <= '0;
      qins0_q <= '0;
      qins1_q <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      qpc0_q  <= qpc0_d;
      qpc1_q  <= qpc1_d;
      qins0_q <= qins0_d;
      qins1_q <= qins1_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  assign imemAddress      = pc_q;
  assign fetchValid       = (count_q != 2'd0);
  // Head outputs read as zero whenever the queue is empty.
  assign fetchInstruction = fetchValid ? qins0_q : 32'h0;
  assign fetchPC          = fetchValid ? qpc0_q : '0;
  assign done             = done_q;
  assign misaligned       = mis_q;

endmodule
`default_nettype wire
